// File: rtl/dlatch_exerciser_pkg.sv
// Shared types and constants for the gated D latch exerciser.
// Holds the FSM encoding, the LFSR tap mask, the default seed and the vector-0 constants.
package dlatch_exerciser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Taps 8,6,5,4 of an 8-bit Fibonacci LFSR, shifted toward the MSB.
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

  // Vector 0 opens the latch with d=0 so both the latch and the model start known.
  localparam logic VEC0_E = 1'b1;
  localparam logic VEC0_D = 1'b0;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  // An all-zero seed would lock the LFSR up.
  function automatic logic [7:0] seed_fix(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

endpackage

// File: rtl/dlx_lfsr8.sv
// 8-bit Fibonacci LFSR used as the latch vector source.
// Loads the (zero-protected) seed on reset or load; advances one step on step.
module dlx_lfsr8
  import dlatch_exerciser_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] state
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= seed_fix(seed);
    end else if (load) begin
      state <= seed_fix(seed);
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/dlatch_exerciser.sv
// Stimulus/response harness for a gated D latch: drives d/e from an LFSR, tracks a golden latch model and scores q/qbar.
// Optional first-failure capture is enabled by defining DLATCH_EXERCISER_FIRST_FAIL_EN.
module dlatch_exerciser
  import dlatch_exerciser_pkg::*;
#(
  parameter int         N_VECTORS     = 16,
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [7:0] LFSR_SEED     = DEFAULT_SEED,
  parameter int         CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             lat_q,
  input  logic             lat_qbar,
  output logic             lat_d,
  output logic             lat_e,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [7:0]       vec_idx
`ifdef DLATCH_EXERCISER_FIRST_FAIL_EN
  ,
  output logic             first_fail_valid,
  output logic [7:0]       first_fail_idx
`endif
);

  localparam int         SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [7:0] LAST_VEC = 8'(N_VECTORS - 1);

  state_t           state, state_nxt;
  logic [SET_W-1:0] settle_cnt;
  logic             settle_last;
  logic             last_vec;
  logic             mq;
  logic             lfsr_load;
  logic             lfsr_step;
  logic [7:0]       lfsr_state;
  logic             drv_d;
  logic             drv_e;
  logic             mismatch;
  logic [CNT_W-1:0] err_nxt;
  logic             unused_lfsr_hi;

  dlx_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (LFSR_SEED),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  assign unused_lfsr_hi = ^lfsr_state[7:2];
  assign settle_last    = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));
  assign last_vec       = (vec_idx == LAST_VEC);
  assign busy           = (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_SAMPLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    mismatch  = 1'b0;
    drv_e     = (vec_idx == 8'd0) ? VEC0_E : lfsr_state[1];
    drv_d     = (vec_idx == 8'd0) ? VEC0_D : lfsr_state[0];
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_DRIVE;
          lfsr_load = 1'b1;
        end
      end
      ST_DRIVE:  state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (settle_last) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        // A healthy latch matches the model and keeps its outputs complementary.
        mismatch  = (lat_q != mq) || (lat_qbar != ~lat_q);
        lfsr_step = 1'b1;
        state_nxt = last_vec ? ST_DONE : ST_DRIVE;
      end
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    err_nxt = err_count;
    if (mismatch && (err_count != {CNT_W{1'b1}})) begin
      err_nxt = err_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_d      <= 1'b0;
      lat_e      <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      vec_idx    <= 8'd0;
      mq         <= 1'b0;
      settle_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_count <= '0;
            pass      <= 1'b0;
            vec_idx   <= 8'd0;
          end
        end
        ST_DRIVE: begin
          lat_d      <= drv_d;
          lat_e      <= drv_e;
          settle_cnt <= '0;
          if (drv_e) mq <= drv_d;
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
        end
        ST_SAMPLE: begin
          err_count <= err_nxt;
          if (last_vec) begin
            // Verdict includes this final sample; close the latch so it holds.
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
            lat_e <= 1'b0;
          end else begin
            vec_idx <= vec_idx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DLATCH_EXERCISER_FIRST_FAIL_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_fail_valid <= 1'b0;
      first_fail_idx   <= 8'd0;
    end else if ((state == ST_IDLE) && start) begin
      first_fail_valid <= 1'b0;
      first_fail_idx   <= 8'd0;
    end else if (mismatch && !first_fail_valid) begin
      first_fail_valid <= 1'b1;
      first_fail_idx   <= vec_idx;
    end
  end
`endif

endmodule

// File: doc/dlatch_exerciser.md
# dlatch_exerciser

Self-checking stimulus and response stage wrapped around the gated D latch (`dlatch`). It drives the latch's `d`/`e` inputs from an LFSR vector sequence and holds a cycle-accurate golden model of the latch. After a settle window it samples the latch's `q`/`qbar` and reports a pass/fail verdict with a saturating mismatch count. It sits directly upstream of the latch, which it feeds, and directly downstream of it, which it consumes, as the latch's built-in test harness.

## Interface
- `N_VECTORS`, 16: vectors per run, legal range 2..256.
- `SETTLE_CYCLES`, 2: cycles the latch inputs are held before sampling, minimum 1.
- `LFSR_SEED`, 8'hA5: initial LFSR state. A value of 0 is replaced by 8'h01.
- `CNT_W`, 8: width of the error counter.
- `clk`  in  1  the single clock; every register updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle run request; honoured only in IDLE.
- `lat_q`  in  1  latch `q`.
- `lat_qbar`  in  1  latch `qbar`.
- `lat_d`  out  1  latch data input, registered.
- `lat_e`  out  1  latch enable input, registered.
- `busy`  out  1  high from DRIVE through SAMPLE.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  verdict of the last completed run; held until the next `start`.
- `err_count`  out  CNT_W  mismatch count, saturating at all-ones.
- `vec_idx`  out  8  index of the vector currently applied.

## Operation
- Reset values: `lat_d`=0, `lat_e`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `vec_idx`=0. State is IDLE, LFSR is loaded with the seed, and the golden model `mq` is 0.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE to DRIVE on `start`. This transition clears `err_count`, `pass` and `vec_idx`, and reloads the LFSR.
- DRIVE, one cycle:
  - Vector 0 is forced to `lat_e`=1, `lat_d`=0, so the latch and `mq` start from a known state.
  - Every other vector uses `lat_d`=lfsr[0] and `lat_e`=lfsr[1].
  - The golden model updates: `mq` takes the new `d` when `e`=1, otherwise it holds.
- SETTLE: count SETTLE_CYCLES cycles with inputs held, then go to SAMPLE.
- SAMPLE, one cycle: a mismatch is `lat_q`≠`mq` OR `lat_qbar`≠~`lat_q`.
  - On a mismatch, `err_count` increments, saturating at all-ones.
  - The LFSR steps once. It is an 8-bit Fibonacci LFSR with taps 8,6,5,4.
  - If `vec_idx`=N_VECTORS-1, go to DONE. Otherwise increment `vec_idx` and go to DRIVE.
- DONE, one cycle: `done`=1, `pass`=(`err_count`==0), `lat_e` goes to 0 so the latch holds, then return to IDLE.
- `start` is ignored outside IDLE. `start` in the DONE cycle is also ignored.
- Reset asserted mid-run returns every output to its reset value on the next edge. The partial run produces no verdict.

## Timing
- `start` sampled high at edge k: the first DRIVE cycle is k+1, and `lat_d`/`lat_e` are valid after edge k+1.
- Each vector takes 2+SETTLE_CYCLES cycles.
- `done` is high in cycle k+1+N_VECTORS·(2+SETTLE_CYCLES). With the defaults this is k+65.
- `lat_d`/`lat_e` are stable from DRIVE through SAMPLE inclusive.
- `err_count` reflects a SAMPLE decision one cycle after that SAMPLE.
- `pass` updates in the same edge that raises `done`.

## Configuration
- `DLATCH_EXERCISER_FIRST_FAIL_EN`, when defined, adds two outputs:
  - `first_fail_valid` (1 bit).
  - `first_fail_idx` (8 bits), holding the `vec_idx` of the first mismatch in a run.
  - Both are cleared on `start` and on reset. They are sticky within a run.
- When the macro is undefined, these ports and their registers do not exist. All other behaviour is identical.

## Structure
- Package `dlatch_exerciser_pkg` holds:
  - The FSM state enum (IDLE, DRIVE, SETTLE, SAMPLE, DONE).
  - The LFSR tap mask constant 8'hB8.
  - The default seed.
  - The vector-0 constants (E=1, D=0).
- One sub-module, `dlx_lfsr8`, with ports `clk`, `rst_n`, `load`, `seed`, `step`, `state[7:0]`.
- The golden latch model and the FSM stay in the top module.

## Test plan
- Behavioural good latch, defaults, `start` at cycle 10: `done` at cycle 75, `pass`=1, `err_count`=0, and `vec_idx` steps 0..15.
- `lat_q` stuck at 0, `lat_qbar`=~`lat_q`: `err_count` equals the number of vectors with `mq`=1 (precomputed from seed A5), and `pass`=0.
- `lat_qbar` tied to `lat_q`: `err_count`=16, and with `DLATCH_EXERCISER_FIRST_FAIL_EN` `first_fail_idx`=0.
- CNT_W=2 with an inverting latch (`q`=~`mq`): `err_count` saturates at 3, no wrap, `pass`=0.
- `start` pulsed during vector 3 is ignored. `rst_n`=0 at vector 5 gives all outputs at reset values the next cycle. A fresh `start` then completes a full 16-vector run with `pass`=1.
- SETTLE_CYCLES=1 and N_VECTORS=2: `done` arrives exactly 7 cycles after `start`, and vector 0 drives `lat_e`=1, `lat_d`=0.
